// File: rtl/nbit_mux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : nbit_mux_pkg                                                 |
// | Shared types and constants for the 4-to-1 round-robin stream mux.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package nbit_mux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_sel_t;

    localparam ch_sel_t RST_LAST_GRANT = 2'd3;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/nbit_4to1_rr_mux_rr_arb_4.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : rr_arb_4                                                     |
// | Combinational 4-way arbiter; RR_ARB_EN selects round-robin, otherwise |
// | fixed priority 0 > 1 > 2 > 3.                                          |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module rr_arb_4
    import nbit_mux_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_sel_t           last_grant,
    input  logic              enable,
    output logic [NUM_CH-1:0] gnt,
    output ch_sel_t           gnt_idx
);

    ch_sel_t idx;
    logic    found;

`ifndef RR_ARB_EN
    // Fixed priority never consults the pointer.
    logic w_unused_last_grant;
    assign w_unused_last_grant = ^last_grant;
`endif

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef RR_ARB_EN
            idx = last_grant + ch_sel_t'(k + 1);
`else
            idx = ch_sel_t'(k);
`endif
            if (enable && !found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nbit_4to1_rr_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : nbit_4to1_rr_mux                                             |
// | Merges four valid/ready streams into one registered, channel-tagged   |
// | stream. Macro RR_ARB_EN enables round-robin arbitration.               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module nbit_4to1_rr_mux
    import nbit_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     in_valid,
    output logic [NUM_CH-1:0]     in_ready,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            sel_out
);

    slot_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    ch_sel_t               sel_q, sel_d;
    ch_sel_t               last_grant_q, last_grant_d;

    logic [NUM_CH-1:0]     gnt;
    ch_sel_t               gnt_idx;
    logic                  slot_free;
    logic                  grant_en;
    logic [DATA_WIDTH-1:0] din_sel;

    // The slot may accept a new beat in the same cycle the held one drains.
    assign slot_free = (state_q == SLOT_EMPTY) || out_ready;
    assign grant_en  = slot_free && !rst;

    rr_arb_4 u_arb (
        .req        (in_valid),
        .last_grant (last_grant_q),
        .enable     (grant_en),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign in_ready = gnt;

    always_comb begin
        case (gnt_idx)
            2'd0:    din_sel = din0;
            2'd1:    din_sel = din1;
            2'd2:    din_sel = din2;
            default: din_sel = din3;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        if (|gnt) begin
            state_d      = SLOT_FULL;
            dout_d       = din_sel;
            sel_d        = gnt_idx;
            last_grant_d = gnt_idx;
        end else if ((state_q == SLOT_FULL) && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SLOT_EMPTY;
            dout_q       <= '0;
            sel_q        <= '0;
            last_grant_q <= RST_LAST_GRANT;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign dout      = dout_q;
    assign sel_out   = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_nbit_4to1_rr_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_nbit_4to1_rr_mux                                          |
// | Scoreboard bench: a queue-based reference model predicts grants and   |
// | output beats; a monitor pops and compares. Honours RR_ARB_EN.          |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_nbit_4to1_rr_mux;

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic [1:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] dout;
    logic [1:0] sel_out;

    int    n_pass  = 0;
    int    n_total = 0;
    beat_t sb[$];
    int    last_g  = 3;

    always #5 clk = ~clk;

    nbit_4to1_rr_mux #(.DATA_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sel_out   (sel_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference arbitration: first requester in the spec's search order.
    function automatic int pick(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
`ifdef RR_ARB_EN
            int c = (last_g + 1 + k) % 4;
`else
            int c = k;
`endif
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One cycle: drive at negedge, check in_ready at +1, commit model at +3.
    task automatic step(input logic r, input logic [3:0] v, input logic ordy,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
        logic [1:0] dat [4];
        int         g;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst = r; in_valid = v; out_ready = ordy;
        din0 = a; din1 = b; din2 = c; din3 = d;
        dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
        #1;
        g = -1;
        if (!r && (sb.size() == 0 || ordy)) g = pick(v);
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        #2;
        if (r) begin
            sb.delete();
            last_g = 3;
        end else if (g >= 0) begin
            sb.push_back({2'(g), dat[g]});
            last_g = g;
        end
    endtask

    // Monitor: compares the presented beat against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (out_valid && sb.size() > 0) begin
                chk("dout", 32'(dout), 32'(sb[0].data));
                chk("sel_out", 32'(sel_out), 32'(sb[0].ch));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        // Reset with all channels requesting.
        step(1'b1, 4'b1111, 1'b1, 2'd1, 2'd2, 2'd3, 2'd1);
        step(1'b1, 4'b1111, 1'b1, 2'd1, 2'd2, 2'd3, 2'd1);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_sel_out", 32'(sel_out), 32'd0);

        // Single channel.
        step(1'b0, 4'b0100, 1'b1, 2'd0, 2'd0, 2'd3, 2'd0);
        step(1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);

        // All channels requesting: arbitration order.
        for (int i = 0; i < 6; i++)
            step(1'b0, 4'b1111, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3);
        step(1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);

        // Backpressure: load ch1 with 1, stall 3 cycles, then release.
        step(1'b0, 4'b0010, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b1000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2);
        step(1'b0, 4'b1000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd2);
        step(1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);

        // Mid-operation reset with a stalled beat and pending requests.
        step(1'b0, 4'b0110, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0);
        step(1'b0, 4'b0110, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0);
        step(1'b1, 4'b0110, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0);
        step(1'b0, 4'b1111, 1'b1, 2'd3, 2'd2, 2'd1, 2'd0);

        // Loopback-style beat: channel 1 carrying 2'b10.
        step(1'b0, 4'b0010, 1'b1, 2'd0, 2'd2, 2'd0, 2'd0);
        step(1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 500; i++)
            step(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 9) < 7),
                 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));

        // Drain.
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b0000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
